bot_if_mc: RTL and testbench



---
 rtl/bot_if_mc_if.sv | 25 ++
 rtl/bot_if_mc.sv | 196 +++++++++++++++++++
 tb/tb_bot_if_mc.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bot_if_mc_if.sv
// rtl/bot_if_mc_if.sv - PicoBlaze I/O port bus between the BOT-simulator CPU and bot_if_mc
// master = PicoBlaze side, slave = register block side.
interface bot_if_mc_if;
    logic       Wr_Strobe;
    logic       Rd_Strobe;
    logic [7:0] AddrIn;
    logic [7:0] DataIn;
    logic [7:0] DataOut;

    modport master (
        output Wr_Strobe,
        output Rd_Strobe,
        output AddrIn,
        output DataIn,
        input  DataOut
    );

    modport slave (
        input  Wr_Strobe,
        input  Rd_Strobe,
        input  AddrIn,
        input  DataIn,
        output DataOut
    );
endinterface

// File: rtl/bot_if_mc.sv
// rtl/bot_if_mc.sv - multi-channel Rojobot register interface for the BOT-simulator PicoBlaze
// Optional watchdog per channel enabled by defining BOT_IF_WATCHDOG_EN.
module bot_if_mc #(
    parameter int          NUM_BOTS  = 2,
    parameter int          WRAP_EN   = 1,
    parameter logic [7:0]  X_HI_TRIG = 8'h7D,
    parameter logic [7:0]  X_HI_DEST = 8'h01,
    parameter logic [7:0]  X_LO_TRIG = 8'h00,
    parameter logic [7:0]  X_LO_DEST = 8'h7B,
    parameter logic [15:0] WD_LIMIT  = 16'd50000
) (
    input  logic                  clk,
    input  logic                  reset,
    bot_if_mc_if.slave            bus,
    input  logic [8*NUM_BOTS-1:0] MotCtl,
    input  logic [8*NUM_BOTS-1:0] BotConfig,
    input  logic [1:0]            MapVal,
    output logic [7:0]            MapX,
    output logic [7:0]            MapY,
    output logic [8*NUM_BOTS-1:0] LocX,
    output logic [8*NUM_BOTS-1:0] LocY,
    output logic [8*NUM_BOTS-1:0] BotInfo,
    output logic [8*NUM_BOTS-1:0] Sensors,
    output logic [NUM_BOTS-1:0]   upd_irq,
    input  logic [NUM_BOTS-1:0]   upd_ack,
    output logic [NUM_BOTS-1:0]   upd_ovf
`ifdef BOT_IF_WATCHDOG_EN
    ,
    output logic [NUM_BOTS-1:0]   bot_alive
`endif
);

    localparam logic [4:0] NB = 5'(NUM_BOTS);

    logic [3:0] chan;
    logic [3:0] offs;
    logic       chan_ok;
    logic [7:0] rd_ch [NUM_BOTS];
    logic [7:0] rd_sel;
    logic       unused_ok;

    assign chan    = bus.AddrIn[7:4];
    assign offs    = bus.AddrIn[3:0];
    assign chan_ok = ({1'b0, chan} < NB);

    // Sidescroller teleport: only the two trigger columns are remapped.
    function automatic logic [7:0] wrap_x(input logic [7:0] x);
        if (WRAP_EN == 0)   return x;
        if (x == X_HI_TRIG) return X_HI_DEST;
        if (x == X_LO_TRIG) return X_LO_DEST;
        return x;
    endfunction

    // World-map address pair is shared; any valid channel may write it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MapX <= 8'h00;
            MapY <= 8'h00;
        end else if (bus.Wr_Strobe && chan_ok) begin
            if (offs == 4'h8) MapX <= bus.DataIn;
            if (offs == 4'h9) MapY <= bus.DataIn;
        end
    end

    always_comb begin
        rd_sel = 8'h00;
        for (int i = 0; i < NUM_BOTS; i++) begin
            if (chan == 4'(i)) rd_sel = rd_ch[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.DataOut <= 8'h00;
        else       bus.DataOut <= rd_sel;
    end

    for (genvar b = 0; b < NUM_BOTS; b++) begin : g_ch
        localparam logic [3:0] CH = 4'(b);

        logic       wr_sel;
        logic       irq_set;
        logic       irq_ack;
        logic [7:0] hold_x, hold_y, hold_info, hold_sens;
        logic [7:0] vis_x, vis_y, vis_info, vis_sens;
        logic       irq, ovf;
        logic [7:0] pet_rd;
        logic [7:0] rd_val;

        assign wr_sel  = bus.Wr_Strobe && (chan == CH);
        assign irq_set = wr_sel && (offs == 4'hE);
        assign irq_ack = upd_ack[b];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hold_x    <= 8'h00;
                hold_y    <= 8'h00;
                hold_info <= 8'h00;
                hold_sens <= 8'h00;
                vis_x     <= 8'h00;
                vis_y     <= 8'h00;
                vis_info  <= 8'h00;
                vis_sens  <= 8'h00;
            end else if (wr_sel) begin
                case (offs)
                    4'h1: hold_x    <= bus.DataIn;
                    4'h2: hold_y    <= bus.DataIn;
                    4'h3: hold_info <= bus.DataIn;
                    4'h4: hold_sens <= bus.DataIn;
                    4'hC: begin
                        vis_x    <= wrap_x(hold_x);
                        vis_y    <= hold_y;
                        vis_info <= hold_info;
                        vis_sens <= hold_sens;
                    end
                    default: ;
                endcase
            end
        end

        // Ack wins over a stale set; a set coinciding with ack never flags overflow.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                irq <= 1'b0;
                ovf <= 1'b0;
            end else if (irq_ack) begin
                irq <= irq_set;
                ovf <= 1'b0;
            end else if (irq_set) begin
                if (irq) ovf <= 1'b1;
                irq <= 1'b1;
            end
        end

`ifdef BOT_IF_WATCHDOG_EN
        logic [15:0] wd_cnt;
        logic        alive;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wd_cnt <= 16'h0000;
                alive  <= 1'b0;
            end else if (wr_sel && (offs == 4'hF)) begin
                wd_cnt <= 16'h0000;
                alive  <= 1'b1;
            end else if (wd_cnt != WD_LIMIT) begin
                wd_cnt <= wd_cnt + 16'd1;
                if (wd_cnt + 16'd1 == WD_LIMIT) alive <= 1'b0;
            end else begin
                alive <= 1'b0;
            end
        end

        assign bot_alive[b] = alive;
        assign pet_rd       = {7'b0, alive};
`else
        assign pet_rd = 8'h00;
`endif

        always_comb begin
            rd_val = 8'h00;
            case (offs)
                4'h0: rd_val = MotCtl[8*b +: 8];
                4'h1: rd_val = wrap_x(hold_x);
                4'h2: rd_val = hold_y;
                4'h3: rd_val = hold_info;
                4'h4: rd_val = hold_sens;
                4'h5: rd_val = 8'h55;
                4'h6: rd_val = 8'h66;
                4'h7: rd_val = BotConfig[8*b +: 8];
                4'h8: rd_val = MapX;
                4'h9: rd_val = MapY;
                4'hA: rd_val = {6'b0, MapVal};
                4'hB: rd_val = 8'hBB;
                4'hE: rd_val = {6'b0, ovf, irq};
                4'hF: rd_val = pet_rd;
                default: rd_val = 8'h00;
            endcase
        end

        assign rd_ch[b]        = rd_val;
        assign LocX[8*b +: 8]    = vis_x;
        assign LocY[8*b +: 8]    = vis_y;
        assign BotInfo[8*b +: 8] = vis_info;
        assign Sensors[8*b +: 8] = vis_sens;
        assign upd_irq[b]        = irq;
        assign upd_ovf[b]        = ovf;
    end

    // Rd_Strobe does not gate reads; DataOut tracks AddrIn every cycle.
`ifdef BOT_IF_WATCHDOG_EN
    assign unused_ok = bus.Rd_Strobe;
`else
    assign unused_ok = bus.Rd_Strobe ^ (^WD_LIMIT);
`endif

endmodule

// File: tb/tb_bot_if_mc.sv
// tb/tb_bot_if_mc.sv - directed-vector bench for bot_if_mc (wrap on, 2 channels; wrap off, 1 channel)
// BOT_IF_WATCHDOG_EN additionally exercises the watchdog with WD_LIMIT=16.
`timescale 1ns/1ps
module tb_bot_if_mc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int vec_count = 0;
    int miss_count = 0;

    bot_if_mc_if bus0();
    bot_if_mc_if bus1();

    logic [15:0] motctl0 = '0, botcfg0 = '0;
    logic [1:0]  mapval = '0;
    logic [7:0]  mapx0, mapy0;
    logic [15:0] locx0, locy0, info0, sens0;
    logic [1:0]  irq0, ack0 = '0, ovf0;

    logic [7:0]  motctl1 = '0, botcfg1 = '0;
    logic [7:0]  mapx1, mapy1, locx1, locy1, info1, sens1;
    logic [0:0]  irq1, ack1 = '0, ovf1;
`ifdef BOT_IF_WATCHDOG_EN
    logic [1:0]  alive0;
    logic [0:0]  alive1;
`endif

    bot_if_mc #(.NUM_BOTS(2), .WRAP_EN(1)
`ifdef BOT_IF_WATCHDOG_EN
        , .WD_LIMIT(16'd16)
`endif
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .MotCtl(motctl0), .BotConfig(botcfg0), .MapVal(mapval),
        .MapX(mapx0), .MapY(mapy0), .LocX(locx0), .LocY(locy0),
        .BotInfo(info0), .Sensors(sens0),
        .upd_irq(irq0), .upd_ack(ack0), .upd_ovf(ovf0)
`ifdef BOT_IF_WATCHDOG_EN
        , .bot_alive(alive0)
`endif
    );

    bot_if_mc #(.NUM_BOTS(1), .WRAP_EN(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .MotCtl(motctl1), .BotConfig(botcfg1), .MapVal(mapval),
        .MapX(mapx1), .MapY(mapy1), .LocX(locx1), .LocY(locy1),
        .BotInfo(info1), .Sensors(sens1),
        .upd_irq(irq1), .upd_ack(ack1), .upd_ovf(ovf1)
`ifdef BOT_IF_WATCHDOG_EN
        , .bot_alive(alive1)
`endif
    );

    task automatic wr(input bit which, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        if (which) begin bus1.Wr_Strobe = 1'b1; bus1.AddrIn = a; bus1.DataIn = d; end
        else       begin bus0.Wr_Strobe = 1'b1; bus0.AddrIn = a; bus0.DataIn = d; end
        @(negedge clk);
        bus0.Wr_Strobe = 1'b0;
        bus1.Wr_Strobe = 1'b0;
    endtask

    task automatic rd(input bit which, input logic [7:0] a, output logic [7:0] v);
        @(negedge clk);
        if (which) bus1.AddrIn = a; else bus0.AddrIn = a;
        @(negedge clk);
        v = which ? bus1.DataOut : bus0.DataOut;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        repeat (2) @(negedge clk);
        vec_count++; if (locx0 !== 16'h0 || locy0 !== 16'h0) begin miss_count++; $display("FAIL reset_loc: got %h/%h expected 0/0", locx0, locy0); end
        vec_count++; if (info0 !== 16'h0 || sens0 !== 16'h0) begin miss_count++; $display("FAIL reset_info: got %h/%h expected 0/0", info0, sens0); end
        vec_count++; if (mapx0 !== 8'h0 || mapy0 !== 8'h0) begin miss_count++; $display("FAIL reset_map: got %h/%h expected 0/0", mapx0, mapy0); end
        vec_count++; if (irq0 !== 2'b0 || ovf0 !== 2'b0) begin miss_count++; $display("FAIL reset_irq: got %b/%b expected 00/00", irq0, ovf0); end
        vec_count++; if (bus0.DataOut !== 8'h0) begin miss_count++; $display("FAIL reset_dout: got %h expected 00", bus0.DataOut); end
        reset = 1'b0;
        rd(0, 8'h01, v);
        vec_count++; if (v !== 8'h7B) begin miss_count++; $display("FAIL reset_hold_wrap: got %h expected 7b", v); end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        wr(0, 8'h01, 8'h7D); wr(0, 8'h0C, 8'h00);
        vec_count++; if (locx0[7:0] !== 8'h01) begin miss_count++; $display("FAIL wrap_hi_vis: got %h expected 01", locx0[7:0]); end
        rd(0, 8'h01, v);
        vec_count++; if (v !== 8'h01) begin miss_count++; $display("FAIL wrap_hi_rd: got %h expected 01", v); end
        wr(0, 8'h01, 8'h00); wr(0, 8'h0C, 8'h00);
        vec_count++; if (locx0[7:0] !== 8'h7B) begin miss_count++; $display("FAIL wrap_lo_vis: got %h expected 7b", locx0[7:0]); end
        rd(0, 8'h01, v);
        vec_count++; if (v !== 8'h7B) begin miss_count++; $display("FAIL wrap_lo_rd: got %h expected 7b", v); end
        wr(0, 8'h01, 8'h42); wr(0, 8'h02, 8'h12); wr(0, 8'h03, 8'h34); wr(0, 8'h04, 8'h56);
        vec_count++; if (locx0[7:0] !== 8'h7B || locy0[7:0] !== 8'h00) begin miss_count++; $display("FAIL hold_no_load: got %h/%h expected 7b/00", locx0[7:0], locy0[7:0]); end
        wr(0, 8'h0C, 8'h00);
        vec_count++; if (locx0[7:0] !== 8'h42) begin miss_count++; $display("FAIL wrap_pass: got %h expected 42", locx0[7:0]); end
        vec_count++; if (locy0[7:0] !== 8'h12 || info0[7:0] !== 8'h34 || sens0[7:0] !== 8'h56) begin miss_count++; $display("FAIL load_all: got %h/%h/%h expected 12/34/56", locy0[7:0], info0[7:0], sens0[7:0]); end
        rd(0, 8'h03, v);
        vec_count++; if (v !== 8'h34) begin miss_count++; $display("FAIL rd_info: got %h expected 34", v); end
        wr(1, 8'h01, 8'h7D); wr(1, 8'h0C, 8'h00);
        vec_count++; if (locx1 !== 8'h7D) begin miss_count++; $display("FAIL nowrap_vis: got %h expected 7d", locx1); end
        rd(1, 8'h01, v);
        vec_count++; if (v !== 8'h7D) begin miss_count++; $display("FAIL nowrap_rd: got %h expected 7d", v); end
        wr(1, 8'h01, 8'h00); wr(1, 8'h0C, 8'h00);
        vec_count++; if (locx1 !== 8'h00) begin miss_count++; $display("FAIL nowrap_zero: got %h expected 00", locx1); end
    endtask

    task automatic test_isolation();
        logic [7:0] v;
        wr(0, 8'h12, 8'h33); wr(0, 8'h1C, 8'h00);
        vec_count++; if (locy0 !== 16'h3312) begin miss_count++; $display("FAIL iso_locy: got %h expected 3312", locy0); end
        vec_count++; if (locx0 !== 16'h7B42) begin miss_count++; $display("FAIL iso_locx: got %h expected 7b42", locx0); end
        wr(0, 8'h21, 8'h99); wr(0, 8'h2C, 8'h00);
        vec_count++; if (locx0 !== 16'h7B42) begin miss_count++; $display("FAIL inval_wr: got %h expected 7b42", locx0); end
        rd(0, 8'h21, v);
        vec_count++; if (v !== 8'h00) begin miss_count++; $display("FAIL inval_rd: got %h expected 00", v); end
        rd(1, 8'h11, v);
        vec_count++; if (v !== 8'h00) begin miss_count++; $display("FAIL nb1_inval_rd: got %h expected 00", v); end
    endtask

    task automatic test_irq();
        logic [7:0] v;
        wr(0, 8'h0E, 8'h00);
        vec_count++; if (irq0 !== 2'b01 || ovf0 !== 2'b00) begin miss_count++; $display("FAIL irq_set: got %b/%b expected 01/00", irq0, ovf0); end
        wr(0, 8'h0E, 8'h00);
        vec_count++; if (irq0 !== 2'b01 || ovf0 !== 2'b01) begin miss_count++; $display("FAIL irq_ovf: got %b/%b expected 01/01", irq0, ovf0); end
        rd(0, 8'h0E, v);
        vec_count++; if (v !== 8'h03) begin miss_count++; $display("FAIL irq_status: got %h expected 03", v); end
        rd(0, 8'h1E, v);
        vec_count++; if (v !== 8'h00) begin miss_count++; $display("FAIL irq_status_b1: got %h expected 00", v); end
        @(negedge clk); ack0 = 2'b01; @(negedge clk); ack0 = 2'b00;
        vec_count++; if (irq0 !== 2'b00 || ovf0 !== 2'b00) begin miss_count++; $display("FAIL irq_ack: got %b/%b expected 00/00", irq0, ovf0); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); ack0 = 2'b01; bus0.Wr_Strobe = 1'b1; bus0.AddrIn = 8'h0E;
            @(negedge clk); ack0 = 2'b00; bus0.Wr_Strobe = 1'b0;
            vec_count++; if (irq0 !== 2'b01 || ovf0 !== 2'b00) begin miss_count++; $display("FAIL irq_set_ack%0d: got %b/%b expected 01/00", k, irq0, ovf0); end
        end
        @(negedge clk); ack0 = 2'b01; @(negedge clk); ack0 = 2'b00;
    endtask

    task automatic test_map();
        logic [7:0] v;
        wr(0, 8'h18, 8'h05); wr(0, 8'h09, 8'h0A);
        vec_count++; if (mapx0 !== 8'h05 || mapy0 !== 8'h0A) begin miss_count++; $display("FAIL map_xy: got %h/%h expected 05/0a", mapx0, mapy0); end
        wr(0, 8'h28, 8'h77);
        vec_count++; if (mapx0 !== 8'h05) begin miss_count++; $display("FAIL map_inval: got %h expected 05", mapx0); end
        mapval = 2'b10;
        rd(0, 8'h0A, v);
        vec_count++; if (v !== 8'h02) begin miss_count++; $display("FAIL mapval_rd: got %h expected 02", v); end
        motctl0 = 16'h00A5;
        rd(0, 8'h00, v);
        vec_count++; if (v !== 8'hA5) begin miss_count++; $display("FAIL motctl_rd: got %h expected a5", v); end
        botcfg0 = 16'hC300;
        rd(0, 8'h17, v);
        vec_count++; if (v !== 8'hC3) begin miss_count++; $display("FAIL botcfg_rd: got %h expected c3", v); end
        rd(0, 8'h15, v);
        vec_count++; if (v !== 8'h55) begin miss_count++; $display("FAIL rsv5_rd: got %h expected 55", v); end
        rd(0, 8'h06, v);
        vec_count++; if (v !== 8'h66) begin miss_count++; $display("FAIL rsv6_rd: got %h expected 66", v); end
        rd(0, 8'h0B, v);
        vec_count++; if (v !== 8'hBB) begin miss_count++; $display("FAIL rsvb_rd: got %h expected bb", v); end
        rd(0, 8'h0F, v);
        vec_count++; if (v !== 8'h00) begin miss_count++; $display("FAIL pet_rd: got %h expected 00", v); end
    endtask

`ifdef BOT_IF_WATCHDOG_EN
    task automatic test_watchdog();
        logic [7:0] v;
        wr(0, 8'h0F, 8'h00);
        vec_count++; if (alive0[0] !== 1'b1) begin miss_count++; $display("FAIL wd_pet: got %b expected 1", alive0[0]); end
        repeat (15) @(negedge clk);
        vec_count++; if (alive0[0] !== 1'b1) begin miss_count++; $display("FAIL wd_early: got %b expected 1", alive0[0]); end
        @(negedge clk);
        vec_count++; if (alive0[0] !== 1'b0) begin miss_count++; $display("FAIL wd_expire: got %b expected 0", alive0[0]); end
        wr(0, 8'h0F, 8'h00);
        vec_count++; if (alive0[0] !== 1'b1) begin miss_count++; $display("FAIL wd_repet: got %b expected 1", alive0[0]); end
        rd(0, 8'h0F, v);
        vec_count++; if (v !== 8'h01) begin miss_count++; $display("FAIL wd_rd: got %h expected 01", v); end
    endtask
`endif

    task automatic test_reset_mid();
        wr(0, 8'h01, 8'h20); wr(0, 8'h0C, 8'h00);
        vec_count++; if (locx0[7:0] !== 8'h20) begin miss_count++; $display("FAIL mid_load: got %h expected 20", locx0[7:0]); end
        wr(0, 8'h0E, 8'h00);
        @(negedge clk); bus0.AddrIn = 8'h00; reset = 1'b1;
        #1;
        vec_count++; if (locx0 !== 16'h0 || irq0 !== 2'b0 || mapx0 !== 8'h0) begin miss_count++; $display("FAIL mid_async: got %h/%b/%h expected 0/0/0", locx0, irq0, mapx0); end
        @(negedge clk);
        vec_count++; if (bus0.DataOut !== 8'h00) begin miss_count++; $display("FAIL mid_dout: got %h expected 00", bus0.DataOut); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus0.Wr_Strobe = 1'b0; bus0.Rd_Strobe = 1'b0; bus0.AddrIn = 8'h00; bus0.DataIn = 8'h00;
        bus1.Wr_Strobe = 1'b0; bus1.Rd_Strobe = 1'b0; bus1.AddrIn = 8'h00; bus1.DataIn = 8'h00;
        test_reset();
        test_wrap();
        test_isolation();
        test_irq();
        test_map();
`ifdef BOT_IF_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule
